// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment back-end for the HH MM SS clock.
// Inputs are snapshotted once per scan frame so a frame never mixes old
// and new time values; the field under adjustment blinks.
module clock_display_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 32
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] edit_sel,
  output logic [6:0] seg,
  output logic [5:0] dig_en,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PW-1:0] prescaler;
  logic [FW-1:0] frame_cnt;
  logic [2:0]    idx;
  logic [5:0]    snap_h, snap_m, snap_s;
  logic [1:0]    snap_sel;
  logic          blink_phase;

  logic          tick, boundary, frame_wrap, phase_next;
  logic [2:0]    idx_next;
  logic [5:0]    cur_h, cur_m, cur_s, field_val;
  logic [1:0]    cur_sel, field_id;
  logic          field_bad;
  logic [3:0]    tens, ones, digit;
  logic [6:0]    seg_next;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // Segment pattern for the digit about to be shown; at a frame boundary the
  // live inputs bypass the snapshot so digit 0 already reflects the new capture.
  always_comb begin
    tick       = (prescaler == PW'(SCAN_DIV - 1));
    boundary   = tick && (idx == 3'd5);
    idx_next   = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    cur_h      = boundary ? hours    : snap_h;
    cur_m      = boundary ? minutes  : snap_m;
    cur_s      = boundary ? seconds  : snap_s;
    cur_sel    = boundary ? edit_sel : snap_sel;
    frame_wrap = (frame_cnt == FW'(BLINK_DIV - 1));
    phase_next = (boundary && frame_wrap) ? ~blink_phase : blink_phase;

    field_val = cur_s;
    field_bad = (cur_s > 6'd59);
    field_id  = 2'b11;
    case (idx_next[2:1])
      2'd0: begin
        field_val = cur_h;
        field_bad = (cur_h > 6'd23);
        field_id  = 2'b01;
      end
      2'd1: begin
        field_val = cur_m;
        field_bad = (cur_m > 6'd59);
        field_id  = 2'b10;
      end
      default: ;
    endcase

    tens  = 4'(field_val / 6'd10);
    ones  = 4'(field_val % 6'd10);
    digit = idx_next[0] ? ones : tens;

    seg_next = field_bad ? 7'h40 : seg_code(digit);
    if (phase_next && (cur_sel != 2'b00) && (cur_sel == field_id))
      seg_next = 7'h00;
  end

  // Scan timing, digit outputs, per-frame snapshot and blink phase.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      prescaler   <= '0;
      frame_cnt   <= '0;
      idx         <= 3'd0;
      dig_en      <= 6'b000001;
      seg         <= 7'h00;
      frame_done  <= 1'b0;
      snap_h      <= 6'd0;
      snap_m      <= 6'd0;
      snap_s      <= 6'd0;
      snap_sel    <= 2'b00;
      blink_phase <= 1'b0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      frame_done <= boundary;
      if (tick) begin
        idx    <= idx_next;
        dig_en <= 6'b000001 << idx_next;
        seg    <= seg_next;
      end
      if (boundary) begin
        snap_h      <= hours;
        snap_m      <= minutes;
        snap_s      <= seconds;
        snap_sel    <= edit_sel;
        blink_phase <= phase_next;
        frame_cnt   <= frame_wrap ? '0 : frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
Display back-end for the digital clock. Consumes binary hour (0-23), minute and second (0-59) values from the counter chain and drives a six-digit, time-multiplexed 7-segment display, HH MM SS. Snapshots inputs once per scan frame so digits never tear. Blinks the field being adjusted.

Parameters:
SCAN_DIV, 1000, clk cycles each digit is held; legal range >= 1.
BLINK_DIV, 32, full scan frames per blink half-period; legal range >= 1.

Ports:
clk  input  1  system clock, rising edge.
clear_n  input  1  asynchronous active-low reset.
hours  input  6  binary hour; valid 0-23.
minutes  input  6  binary minute; valid 0-59.
seconds  input  6  binary second; valid 0-59.
edit_sel  input  2  field to blink: 00 none, 01 hours, 10 minutes, 11 seconds.
seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
dig_en  output  6  one-hot digit enable, active-high, registered; bit0 = hours tens (leftmost), bit5 = seconds ones.
frame_done  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset is asynchronous and active-low on clear_n. One clock.
- Reset values: prescaler 0, idx 0, dig_en 6'b000001, seg 7'h00 (blank), frame_done 0. Snapshot registers and blink_phase are also 0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. A tick is the edge where the prescaler equals SCAN_DIV-1.
- On each tick:
  - idx advances 0->1->...->5->0.
  - dig_en and seg load the values for the new idx on the same edge, so each digit is held exactly SCAN_DIV cycles.
- Frame boundary is the tick where idx goes 5->0. On that edge:
  - hours, minutes, seconds and edit_sel are captured into the snapshot.
  - frame_done pulses high for exactly 1 cycle.
  - Digit 0 of the new frame uses the values just captured, via a bypass from the live inputs.
- Between frame boundaries, input changes have no visible effect.
- Digit mapping: idx0/1 = hours tens/ones, idx2/3 = minutes tens/ones, idx4/5 = seconds tens/ones.
- Conversion: tens = v/10, ones = v%10, from the 6-bit value.
- Out-of-range value (hours > 23, minutes or seconds > 59): both digits of that field show a dash, 7'h40.
- Segment codes: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
- Blink:
  - A frame counter counts frame boundaries 0..BLINK_DIV-1. On wrap it toggles blink_phase.
  - blink_phase 0 = visible; it starts at 0 after reset.
  - When blink_phase = 1, digits of the snapshot-selected field output seg 7'h00. dig_en still scans normally.
  - Other fields are unaffected. edit_sel = 00 disables blanking.
- After reset release, digit 0 stays blank until the first tick at cycle SCAN_DIV, which moves to idx1. Normal display begins at the first frame boundary.
- Reset mid-frame: outputs return to reset values immediately, without waiting for clk. Scanning restarts from idx0.

Test Plan:
1. Reset: assert clear_n=0 mid-cycle -> immediately seg=00, dig_en=000001, frame_done=0. Hold these values through release until cycle SCAN_DIV.
2. SCAN_DIV=4, BLINK_DIV=2, hours=13, minutes=45, seconds=7, edit_sel=00 -> after the first frame boundary:
   - seg sequence 06,4F,66,6D,3F,07.
   - dig_en walks bit0..bit5, each held 4 cycles.
   - frame_done pulses once every 24 cycles.
3. Snapshot: change minutes from 45 to 59 while idx=1 -> the rest of this frame still shows 4,5; the next frame shows 5,9 (6D,6F).
4. Out-of-range: hours=24, seconds=60, minutes=0 -> seg sequence 40,40,3F,3F,40,40.
5. Blink: edit_sel=10, BLINK_DIV=2 -> minutes digits show 00 in frames 2-3 and 6-7 and are visible in frames 0-1 and 4-5. Hours and seconds digits are always visible.
6. Rollover: sweep hours 23->0 and minutes/seconds 59->0 across frame boundaries -> display 23:59:59 then 00:00:00, with no dash and no torn frame.
